// File: rtl/matrix2x2_result_drain.sv
// Serializes one packed 2x2 matrix into four row-major elements over valid/ready; c00 appears
// the cycle after acceptance, elements hold while stalled, and a new matrix is taken during the c11 transfer.
module matrix2x2_result_drain #(
  parameter int ELEM_W = 17,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*ELEM_W-1:0]   in_mat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ELEM_W-1:0]     out_data,
  output logic [1:0]            out_idx,
  output logic                  out_last,
  output logic [CNT_W-1:0]      mat_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q;
  logic [1:0]            idx_q;
  logic [4*ELEM_W-1:0]   hold_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  xfer;
  logic                  accept;

  assign xfer      = (state_q == SEND) && out_ready;
  // Combinational path from out_ready lets the next matrix load while c11 leaves.
  assign in_ready  = (state_q == IDLE) || ((state_q == SEND) && (idx_q == 2'd3) && out_ready);
  assign accept    = in_valid && in_ready;

  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_last  = (state_q == SEND) && (idx_q == 2'd3);
  assign mat_count = cnt_q;

  always_comb begin
    out_data = '0;
    case (idx_q)
      2'd0:    out_data = hold_q[4*ELEM_W-1:3*ELEM_W];
      2'd1:    out_data = hold_q[3*ELEM_W-1:2*ELEM_W];
      2'd2:    out_data = hold_q[2*ELEM_W-1:ELEM_W];
      default: out_data = hold_q[ELEM_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            hold_q  <= in_mat;
            idx_q   <= 2'd0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx_q != 2'd3) begin
              idx_q <= idx_q + 2'd1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              idx_q <= 2'd0;
              if (accept) begin
                hold_q <= in_mat;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix2x2_result_drain.sv
module tb_matrix2x2_result_drain;

  localparam int EW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4*EW-1:0] in_mat = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [EW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic [7:0]    mat_count;

  logic          in_ready_w, out_valid_w, out_last_w;
  logic [EW-1:0] out_data_w;
  logic [1:0]    out_idx_w;
  logic [1:0]    mat_count_w;

  matrix2x2_result_drain #(.ELEM_W(EW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .mat_count(mat_count)
  );

  // Narrow-counter instance shares the stimulus; only its counter is of interest.
  matrix2x2_result_drain #(.ELEM_W(EW), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_mat(in_mat),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w), .out_idx(out_idx_w),
    .out_last(out_last_w), .mat_count(mat_count_w)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the drain: busy flag, element index, drain count, element queue.
  logic [EW-1:0] sb[$];
  logic          m_busy = 1'b0;
  logic [1:0]    m_idx  = 2'd0;
  logic [7:0]    m_cnt  = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_idx  = 2'd0;
      m_cnt  = 8'd0;
      sb.delete();
    end else if (m_busy) begin
      if (out_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        if (m_idx == 2'd3) begin
          m_cnt = m_cnt + 8'd1;
          m_idx = 2'd0;
          if (!in_valid) m_busy = 1'b0;
        end else begin
          m_idx = m_idx + 2'd1;
        end
      end
    end else if (in_valid) begin
      m_busy = 1'b1;
      m_idx  = 2'd0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  {15'd0, out_data},  32'd0);
      check("rst_out_idx",   {30'd0, out_idx},   32'd0);
      check("rst_out_last",  {31'd0, out_last},  32'd0);
      check("rst_mat_count", {24'd0, mat_count}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    end else begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
      check("in_ready", {31'd0, in_ready},
            {31'd0, (!m_busy) || (m_idx == 2'd3 && out_ready)});
      check("mat_count", {24'd0, mat_count}, {24'd0, m_cnt});
      check("mat_count_w2", {30'd0, mat_count_w}, {30'd0, m_cnt[1:0]});
      if (m_busy) begin
        check("out_idx",  {30'd0, out_idx},  {30'd0, m_idx});
        check("out_last", {31'd0, out_last}, {31'd0, m_idx == 2'd3});
        if (sb.size() > 0) check("out_data", {15'd0, out_data}, {15'd0, sb[0]});
        else               check("sb_underflow", 32'd1, 32'd0);
      end
    end
  end

  // out_ready pattern generator: steady 1, or 1,0,0 repeating when bp is set.
  logic bp = 1'b0;
  initial begin
    int bpc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        out_ready = (bpc == 0);
        bpc = (bpc == 2) ? 0 : bpc + 1;
      end else begin
        out_ready = 1'b1;
        bpc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_mat(input logic [4*EW-1:0] m);
    logic acc;
    sb.push_back(m[4*EW-1:3*EW]);
    sb.push_back(m[3*EW-1:2*EW]);
    sb.push_back(m[2*EW-1:EW]);
    sb.push_back(m[EW-1:0]);
    in_valid = 1'b1;
    in_mat   = m;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && m_busy; i++) tick();
    check("drain_done", {31'd0, m_busy}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);
  endtask

  function automatic logic [4*EW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [EW-1:0] ea, eb, ec, ed;
    ea = a[EW-1:0]; eb = b[EW-1:0]; ec = c[EW-1:0]; ed = d[EW-1:0];
    return {ea, eb, ec, ed};
  endfunction

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();

    send_mat(pack(19, 22, 43, 50));
    wait_drain();
    check("single_count", {24'd0, mat_count}, 32'd1);

    send_mat(pack(1001, 2002, 3003, 4004));
    send_mat(pack(130050, 0, 65535, 7));
    wait_drain();
    check("b2b_count", {24'd0, mat_count}, 32'd3);

    bp = 1'b1;
    send_mat(pack(11, 12, 13, 14));
    wait_drain();
    bp = 1'b0;

    send_mat(pack(500, 600, 700, 800));
    tick();
    send_mat(pack(1, 2, 3, 4));
    wait_drain();
    check("ignore_count", {24'd0, mat_count}, 32'd6);

    send_mat(pack(9, 9, 9, 9));
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    for (int k = 0; k < 5; k++) begin
      send_mat(pack($urandom_range(0, 130050), $urandom_range(0, 130050),
                    $urandom_range(0, 130050), $urandom_range(0, 130050)));
      wait_drain();
    end
    check("wrap_count_w2", {30'd0, mat_count_w}, 32'd1);
    check("wrap_count", {24'd0, mat_count}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix2x2_result_drain.md
# matrix2x2_result_drain

Consumer-side serializer for the 2x2 matrix datapath. It accepts one fully packed 2x2 product matrix per handshake and emits its four elements one per transfer, in row-major order, over a valid/ready stream. It sits downstream of the parallel 2x2 matrix multiplier and feeds narrow-width sinks (result memory, UART bridge, scoreboard). It also keeps a running count of matrices fully drained.

## Interface
Parameters:
- ELEM_W, 17, width of one product element (8b×8b products summed in pairs: max 2·255·255 = 130050 < 2^17)
- CNT_W, 8, width of the drained-matrix counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  packed matrix on in_mat is valid
- in_ready  output  1  block can accept a matrix this cycle
- in_mat  input  4*ELEM_W  packed matrix {c00, c01, c10, c11}; c00 in the MSBs
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  sink accepts the element this cycle
- out_data  output  ELEM_W  current element
- out_idx  output  2  element index: 0=c00, 1=c01, 2=c10, 3=c11
- out_last  output  1  high while out_idx==3 and out_valid
- mat_count  output  CNT_W  matrices fully drained since reset; wraps modulo 2^CNT_W

## Operation
- The clock and reset are one clock, `clk`, with an asynchronous, active-high reset, `rst`.
- Single holding register `hold` (4*ELEM_W), 2-bit index counter `idx`, and a two-state FSM: IDLE, SEND.
- IDLE: in_ready=1, out_valid=0. If in_valid, the block latches in_mat into hold, sets idx=0 and moves to SEND.
- SEND: out_valid=1, and out_data = the element of hold selected by idx (idx 0 → bits [4*ELEM_W-1:3*ELEM_W], …, idx 3 → bits [ELEM_W-1:0]).
  - Transfer occurs when out_valid && out_ready.
  - On a transfer with idx<3, idx increments.
  - On a transfer with idx==3 (last), mat_count increments.
  - After the last transfer: if in_valid is also high that cycle, hold reloads, idx=0 and the FSM stays in SEND (back-to-back). Otherwise the FSM goes to IDLE.
- in_ready = (state==IDLE) || (state==SEND && idx==3 && out_ready). This is combinational from out_ready, and intentional.
- in_mat is sampled only on in_valid && in_ready. It is ignored otherwise, and hold is never overwritten mid-drain.
- Stall: while out_valid && !out_ready, out_data, out_idx and out_last hold stable.
- out_valid never drops without a transfer, except on reset.
- mat_count wrap: the value 2^CNT_W−1 plus one drain gives 0.

## Timing
- Reset (asynchronous assert, release synchronous to clk): state=IDLE, idx=0, hold=0, mat_count=0, out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=1 (after release).
- Reset mid-drain: the partially sent matrix is discarded and no count is made.
- Latency: matrix accepted at edge N gives out_valid with c00 in cycle N+1.
- Throughput: with out_ready held at 1, one element per cycle and one matrix per 4 cycles, with no bubble between matrices when in_valid is held.
- mat_count updates at the edge that completes the c11 transfer, and is visible the next cycle.
- in_valid while busy and idx<3: in_ready=0, nothing captured. The source must hold in_valid and in_mat.

## Test plan
- Reset/idle: assert rst mid-run → all outputs 0 and in_ready=1 after release. Hold in_valid=0 for 10 cycles → out_valid stays 0.
- Single matrix, out_ready=1:
  - Stimulus: in_mat = {17'd19, 17'd22, 17'd43, 17'd50}, the product of [1 2;3 4]×[5 6;7 8].
  - Required: out_data 19, 22, 43, 50 on consecutive cycles, with out_idx 0..3.
  - Required: out_last only with 50, then mat_count=1.
- Back-to-back: two matrices, with in_valid held, and out_ready=1.
  - Required: 8 consecutive elements with no bubble.
  - Required: the second matrix is accepted on the cycle 50 transfers.
  - Required: mat_count=2.
- Backpressure: out_ready toggles 1,0,0,1,… during a drain.
  - Required: each element holds steady across stall cycles, with no loss or duplication, and in_ready=0 until the c11 transfer.
- Input ignored while busy: present a second matrix {1,2,3,4} with in_valid while idx=1.
  - Required: the first matrix output is unaffected.
  - Required: the second matrix is captured only when idx==3 with out_ready=1.
- Counter wrap (CNT_W=2): drain 5 matrices → mat_count 1,2,3,0,1.
